hwpe_stream_sink_shaper: RTL

- Synthesizable, parametrised HWPE-Stream sink that generates configurable backpressure and accounts for the traffic it absorbs.
- Terminates a stream at the end of a datapath (FPGA emulation, on-chip self-test, bench).
- Replaces ad-hoc behavioural ready generators with four LFSR/counter-driven ready modes, beat/stall counters, a data checksum, a completion pulse and a sticky protocol-violation flag.

---
 rtl/hwpe_stream_sink_shaper.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/hwpe_stream_sink_shaper.sv
// hwpe_stream_sink_shaper
//
// HWPE-Stream sink with configurable backpressure and traffic accounting.
// It terminates a stream and drives ready_o from one of four sources:
//   FORCE    - always ready
//   RANDOM   - ready from a 16-bit Galois LFSR compared to a threshold
//   PERIODIC - ON/OFF duty-cycle FSM
//   HOLD     - never ready
// It counts accepted beats and stalled cycles, folds the accepted data into a
// rotate-xor checksum, pulses done_o when a programmed beat count is reached,
// and latches error_o when the source breaks the valid/data stability rules.
//
// Ports:
//   clk_i          clock
//   clear_i        synchronous active-high reset
//   enable_i       freezes ready_o (RANDOM, PERIODIC) when low
//   mode_i         0=FORCE 1=RANDOM 2=PERIODIC 3=HOLD
//   stall_thresh_i RANDOM stall probability, thresh/1024
//   on_cycles_i    PERIODIC ready-high length
//   off_cycles_i   PERIODIC ready-low length
//   expected_i     beat count that fires done_o (0 disables)
//   valid_i        stream valid
//   data_i         stream data
//   strb_i         stream byte strobes
//   ready_o        stream ready (registered)
//   beat_cnt_o     accepted handshakes (saturating)
//   stall_cnt_o    cycles with valid_i=1 and ready_o=0 (saturating)
//   checksum_o     running rotl1-xor checksum of accepted data
//   done_o         one-cycle completion pulse
//   error_o        sticky protocol-violation flag

module hwpe_stream_sink_shaper #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 32,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                    clk_i,
  input  logic                    clear_i,
  input  logic                    enable_i,
  input  logic [1:0]              mode_i,
  input  logic [9:0]              stall_thresh_i,
  input  logic [7:0]              on_cycles_i,
  input  logic [7:0]              off_cycles_i,
  input  logic [CNT_WIDTH-1:0]    expected_i,
  input  logic                    valid_i,
  input  logic [DATA_WIDTH-1:0]   data_i,
  input  logic [DATA_WIDTH/8-1:0] strb_i,
  output logic                    ready_o,
  output logic [CNT_WIDTH-1:0]    beat_cnt_o,
  output logic [CNT_WIDTH-1:0]    stall_cnt_o,
  output logic [DATA_WIDTH-1:0]   checksum_o,
  output logic                    done_o,
  output logic                    error_o
);

  localparam int unsigned NB = DATA_WIDTH / 8;

  localparam logic [1:0]  MODE_FORCE    = 2'd0;
  localparam logic [1:0]  MODE_RANDOM   = 2'd1;
  localparam logic [1:0]  MODE_PERIODIC = 2'd2;
  localparam logic [1:0]  MODE_HOLD     = 2'd3;

  localparam logic [15:0] LFSR_POLY = 16'hB400;

  typedef enum logic {
    PH_ON  = 1'b0,
    PH_OFF = 1'b1
  } phase_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic                  ready_q,     ready_d;
  logic [15:0]           lfsr_q,      lfsr_d;
  phase_e                phase_q,     phase_d;
  logic [7:0]            phase_cnt_q, phase_cnt_d;
  logic [CNT_WIDTH-1:0]  beat_q,      beat_d;
  logic [CNT_WIDTH-1:0]  stall_q,     stall_d;
  logic [DATA_WIDTH-1:0] chk_q,       chk_d;
  logic                  done_q,      done_d;
  logic                  fired_q,     fired_d;
  logic                  error_q,     error_d;
  // Previous-cycle stall and payload, used to detect an unstable source.
  logic                  was_stall_q, was_stall_d;
  logic [DATA_WIDTH-1:0] data_prev_q, data_prev_d;
  logic [NB-1:0]         strb_prev_q, strb_prev_d;

  // ---------------------------------------------------------------------------
  // Byte-expanded strobe mask
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] strb_mask;

  for (genvar gi = 0; gi < NB; gi++) begin : g_strb
    assign strb_mask[gi*8 +: 8] = {8{strb_i[gi]}};
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  logic       handshake;
  logic       stall_now;
  logic       eff_on;
  logic [7:0] eff_cnt;

  always_comb begin
    handshake   = valid_i && ready_q;
    stall_now   = valid_i && !ready_q;

    lfsr_d      = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_POLY : 16'h0000);
    ready_d     = ready_q;
    phase_d     = phase_q;
    phase_cnt_d = phase_cnt_q;
    eff_on      = 1'b0;
    eff_cnt     = 8'd0;

    case (mode_i)
      MODE_FORCE: ready_d = 1'b1;
      MODE_HOLD:  ready_d = 1'b0;
      MODE_RANDOM: begin
        // Only resample while something is offered or we are not ready, so an
        // idle input never sees ready fall.
        if (enable_i && (valid_i || !ready_q)) begin
          ready_d = (lfsr_q[9:0] >= stall_thresh_i);
        end
      end
      default: begin // MODE_PERIODIC
        if (enable_i) begin
          // A phase whose count is exhausted (including a zero-length phase)
          // hands over to the other phase in this same cycle.
          eff_on  = (phase_q == PH_ON);
          eff_cnt = phase_cnt_q;
          if (eff_on && (phase_cnt_q >= on_cycles_i)) begin
            eff_on  = 1'b0;
            eff_cnt = 8'd0;
          end else if (!eff_on && (phase_cnt_q >= off_cycles_i)) begin
            eff_on  = 1'b1;
            eff_cnt = 8'd0;
          end

          if (eff_on) begin
            if (on_cycles_i != 8'd0) begin
              ready_d     = 1'b1;
              phase_d     = PH_ON;
              phase_cnt_d = eff_cnt + 8'd1;
            end else if (off_cycles_i != 8'd0) begin
              ready_d     = 1'b0;
              phase_d     = PH_OFF;
              phase_cnt_d = 8'd1;
            end else begin
              ready_d     = 1'b0;
              phase_d     = PH_ON;
              phase_cnt_d = 8'd0;
            end
          end else begin
            if (off_cycles_i != 8'd0) begin
              ready_d     = 1'b0;
              phase_d     = PH_OFF;
              phase_cnt_d = eff_cnt + 8'd1;
            end else if (on_cycles_i != 8'd0) begin
              ready_d     = 1'b1;
              phase_d     = PH_ON;
              phase_cnt_d = 8'd1;
            end else begin
              ready_d     = 1'b0;
              phase_d     = PH_ON;
              phase_cnt_d = 8'd0;
            end
          end
        end
      end
    endcase

    // Any other mode parks the duty cycle so re-entry starts a fresh ON phase.
    if (mode_i != MODE_PERIODIC) begin
      phase_d     = PH_ON;
      phase_cnt_d = 8'd0;
    end

    // Saturating counters.
    beat_d = beat_q;
    if (handshake && (beat_q != '1)) begin
      beat_d = beat_q + 1'b1;
    end
    stall_d = stall_q;
    if (stall_now && (stall_q != '1)) begin
      stall_d = stall_q + 1'b1;
    end

    // The checksum keeps folding even once the beat counter is saturated.
    chk_d = chk_q;
    if (handshake) begin
      chk_d = {chk_q[DATA_WIDTH-2:0], chk_q[DATA_WIDTH-1]} ^ (data_i & strb_mask);
    end

    // done_o fires once, on the beat that actually moves the count onto target.
    done_d  = handshake && (expected_i != '0) && (beat_d != beat_q) &&
              (beat_d == expected_i) && !fired_q;
    fired_d = fired_q || done_d;

    was_stall_d = stall_now;
    data_prev_d = data_i;
    strb_prev_d = strb_i;
    error_d     = error_q ||
                  (was_stall_q && (!valid_i || (data_i != data_prev_q) ||
                                   (strb_i != strb_prev_q)));
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      ready_q     <= 1'b0;
      lfsr_q      <= LFSR_SEED;
      phase_q     <= PH_ON;
      phase_cnt_q <= 8'd0;
      beat_q      <= '0;
      stall_q     <= '0;
      chk_q       <= '0;
      done_q      <= 1'b0;
      fired_q     <= 1'b0;
      error_q     <= 1'b0;
      was_stall_q <= 1'b0;
      data_prev_q <= '0;
      strb_prev_q <= '0;
    end else begin
      ready_q     <= ready_d;
      lfsr_q      <= lfsr_d;
      phase_q     <= phase_d;
      phase_cnt_q <= phase_cnt_d;
      beat_q      <= beat_d;
      stall_q     <= stall_d;
      chk_q       <= chk_d;
      done_q      <= done_d;
      fired_q     <= fired_d;
      error_q     <= error_d;
      was_stall_q <= was_stall_d;
      data_prev_q <= data_prev_d;
      strb_prev_q <= strb_prev_d;
    end
  end

  assign ready_o     = ready_q;
  assign beat_cnt_o  = beat_q;
  assign stall_cnt_o = stall_q;
  assign checksum_o  = chk_q;
  assign done_o      = done_q;
  assign error_o     = error_q;

endmodule
